bf16_adder_arbiter: RTL and testbench
=====================================

BF16_ADDER_ARBITER -- requirements
Module: bf16_adder_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width (bf16).
REQ-002 Parameter NUM_REQ, default 4, number of requesters; the block SHALL support only the value 4.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_a  in  64  packed operand A; requester i uses bits [16i+15:16i].
REQ-006 req_b  in  64  packed operand B; same packing as req_a.
REQ-007 req_STB  in  4  per-requester request strobe.
REQ-008 req_BUSY  out  4  per-requester busy; low only for the granted requester while in IDLE.
REQ-009 adder_a, adder_b  out  16 each  operands to the shared adder_bf16.
REQ-010 adder_input_STB  out  1  operand strobe to the adder.
REQ-011 adder_BUSY  in  1  adder input busy.
REQ-012 adder_sum  in  16  adder result.
REQ-013 adder_output_STB  in  1  adder result strobe.
REQ-014 adder_output_module_BUSY  out  1  busy back to the adder output.
REQ-015 out_result  out  16  delivered sum.
REQ-016 out_id  out  2  index of the requester that owns out_result.
REQ-017 out_STB  out  1  result strobe.
REQ-018 output_module_BUSY  in  1  downstream busy.
REQ-019 txn_count  out  16  number of completed deliveries.

Function
REQ-020 Handshake rule, all STB/BUSY pairs: a transfer SHALL occur on a rising edge where STB=1 and BUSY=0; STB, once raised, SHALL hold with data stable until that transfer.
REQ-021 FSM states: IDLE, ISSUE, WAIT_SUM, DELIVER; exactly one transaction in flight.
REQ-022 Grant: round-robin, combinational from req_STB and pointer rr_ptr; search order starts at rr_ptr, then rr_ptr+1, wrapping modulo 4.
REQ-023 req_BUSY[i] SHALL be 0 only when state=IDLE and i is the grant; all other bits SHALL be 1.
REQ-024 IDLE: on a transfer from grant g, latch req_a/req_b slice g into adder_a/adder_b, latch g as owner, go to ISSUE; with no req_STB set, remain in IDLE.
REQ-025 ISSUE: adder_input_STB=1; on the edge with adder_BUSY=0, set adder_input_STB=0 and go to WAIT_SUM.
REQ-026 WAIT_SUM: adder_output_module_BUSY=0; on adder_output_STB=1, latch adder_sum into out_result, set out_id=owner, set adder_output_module_BUSY=1, set out_STB=1, go to DELIVER.
REQ-027 Outside WAIT_SUM, adder_output_module_BUSY SHALL be 1.
REQ-028 DELIVER: on the edge with output_module_BUSY=0, set out_STB=0, set rr_ptr=(owner+1) mod 4, increment txn_count (wraps 0xFFFF->0), go to IDLE.
REQ-029 Minimum latency: requester transfer to out_STB high is 3 cycles plus adder compute time; a new grant SHALL occur no sooner than the cycle after DELIVER completes.
REQ-030 Simultaneous requests: only the grant transfers; the others keep req_BUSY=1 and SHALL be served in rotation order.
REQ-031 A requester dropping req_STB before grant SHALL NOT be served and SHALL NOT move rr_ptr.
REQ-032 out_result/out_id SHALL remain stable while out_STB=1.

Reset
REQ-033 Asserting rst at any time, including mid-transaction, SHALL immediately force: state=IDLE, rr_ptr=0, adder_input_STB=0, adder_output_module_BUSY=1, out_STB=0, out_result=0, out_id=0, adder_a=adder_b=0, txn_count=0.
REQ-034 An in-flight transaction SHALL be discarded on reset and never delivered.
REQ-035 After rst deasserts, the first grant SHALL go to the lowest-index requester with req_STB set.

Verification
REQ-036 Single request: req 1 a=0x3F80 (1.0), b=0x4000 (2.0) -> out_STB with out_result=0x4040, out_id=1, txn_count=1.
REQ-037 All four req_STB high continuously after reset -> grants in order 0,1,2,3,0; each req_BUSY low for exactly one cycle per grant.
REQ-038 out_STB held with output_module_BUSY=1 for 10 cycles -> out_result/out_id unchanged, no new grant, req_BUSY all 1.
REQ-039 adder_BUSY=1 for 5 cycles in ISSUE -> adder_input_STB stays 1, adder_a/adder_b stable, then drop after acceptance.
REQ-040 rst pulsed during WAIT_SUM, then adder_output_STB=1 -> no out_STB; next request from req 2 delivers with out_id=2, txn_count=1.
REQ-041 0xFFFF completed transactions then one more -> txn_count=0x0000.

Source files
------------

// File: rtl/bf16_adder_arbiter.sv
// bf16_adder_arbiter: round-robin arbiter sharing one bf16 adder among four requesters
module bf16_adder_arbiter #(
    parameter int DATA_W  = 16,
    parameter int NUM_REQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_STB,
    output logic [NUM_REQ-1:0]        req_BUSY,
    output logic [DATA_W-1:0]         adder_a,
    output logic [DATA_W-1:0]         adder_b,
    output logic                      adder_input_STB,
    input  logic                      adder_BUSY,
    input  logic [DATA_W-1:0]         adder_sum,
    input  logic                      adder_output_STB,
    output logic                      adder_output_module_BUSY,
    output logic [DATA_W-1:0]         out_result,
    output logic [1:0]                out_id,
    output logic                      out_STB,
    input  logic                      output_module_BUSY,
    output logic [15:0]               txn_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_SUM, DELIVER} state_t;
    state_t     state;
    logic [1:0] rr_ptr;
    logic [1:0] owner;
    logic [1:0] grant;
    logic       grant_vld;
    // Round-robin pick: scan offsets downward so the requester nearest rr_ptr wins last
    always_comb begin
        grant     = rr_ptr;
        grant_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_STB[rr_ptr + 2'(k)]) begin
                grant     = rr_ptr + 2'(k);
                grant_vld = 1'b1;
            end
        end
    end
    // Only the granted requester sees BUSY low, and only while no transaction is in flight
    always_comb begin
        req_BUSY = '1;
        if (state == IDLE && grant_vld) req_BUSY[grant] = 1'b0;
    end
    // Transaction sequencer: accept, issue to adder, collect sum, deliver, rotate pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                    <= IDLE;
            rr_ptr                   <= '0;
            owner                    <= '0;
            adder_a                  <= '0;
            adder_b                  <= '0;
            adder_input_STB          <= 1'b0;
            adder_output_module_BUSY <= 1'b1;
            out_result               <= '0;
            out_id                   <= '0;
            out_STB                  <= 1'b0;
            txn_count                <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        adder_a         <= req_a[DATA_W*int'(grant) +: DATA_W];
                        adder_b         <= req_b[DATA_W*int'(grant) +: DATA_W];
                        owner           <= grant;
                        adder_input_STB <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!adder_BUSY) begin
                        adder_input_STB          <= 1'b0;
                        adder_output_module_BUSY <= 1'b0;
                        state                    <= WAIT_SUM;
                    end
                end
                WAIT_SUM: begin
                    if (adder_output_STB) begin
                        out_result               <= adder_sum;
                        out_id                   <= owner;
                        adder_output_module_BUSY <= 1'b1;
                        out_STB                  <= 1'b1;
                        state                    <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (!output_module_BUSY) begin
                        out_STB   <= 1'b0;
                        rr_ptr    <= owner + 2'd1;
                        txn_count <= txn_count + 16'd1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bf16_adder_arbiter.sv
// tb_bf16_adder_arbiter: self-checking bench with behavioural requesters, adder and consumer
module tb_bf16_adder_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req_a, req_b;
    logic [3:0]  req_STB, req_BUSY;
    logic [15:0] adder_a, adder_b, adder_sum, out_result, txn_count;
    logic        adder_input_STB, adder_BUSY, adder_output_STB, adder_output_module_BUSY;
    logic        out_STB, output_module_BUSY;
    logic [1:0]  out_id;

    bf16_adder_arbiter #(.DATA_W(16), .NUM_REQ(4)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_STB(req_STB), .req_BUSY(req_BUSY),
        .adder_a(adder_a), .adder_b(adder_b), .adder_input_STB(adder_input_STB), .adder_BUSY(adder_BUSY),
        .adder_sum(adder_sum), .adder_output_STB(adder_output_STB),
        .adder_output_module_BUSY(adder_output_module_BUSY), .out_result(out_result), .out_id(out_id),
        .out_STB(out_STB), .output_module_BUSY(output_module_BUSY), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, issued = 0;
    // requesters: pending operation count and current operands per port
    logic [15:0] cur_a [4], cur_b [4];
    int          rem [4];
    // reference model of the arbiter, tracked from handshake events only
    int          m_ptr, m_owner;
    bit          m_idle, m_issue, m_wait, m_outstb;
    logic [15:0] m_opa, m_opb, m_res, m_txn;
    int          grant_log [$];
    int          deliv_cnt = 0, last_id;
    logic [15:0] last_res;
    // behavioural adder and consumer
    bit          ad_pend;
    int          ad_cnt, lat_lo, lat_hi, a_busy_mode, o_busy_mode;
    logic [15:0] ad_val;
    // values present just before the next rising edge
    logic [3:0]  s_req_stb, s_req_busy;
    logic        s_ai_stb, s_a_busy, s_ao_stb, s_aomb, s_out_stb, s_omb;
    logic [15:0] s_adder_a, s_adder_b, s_out_result;
    logic [1:0]  s_out_id;
    logic [63:0] s_a, s_b;

    typedef struct { logic [1:0] id; logic [15:0] a, b, sum, cnt; } vec_t;
    vec_t tbl [6];
    int   exp_rr [5];

    function automatic real bf_to_r(input logic [15:0] x);
        logic [63:0] d;
        if (x[14:7] == 8'd0) return 0.0;
        d = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] r_to_bf(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 16'h0000;
        return {d[63], 8'(d[62:52] - 11'd896), d[51:45]};
    endfunction

    function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b);
        return r_to_bf(bf_to_r(a) + bf_to_r(b));
    endfunction

    function automatic logic [15:0] rnd_bf();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(115, 135)), 7'($urandom_range(0, 127))};
    endfunction

    function automatic logic busy_of(input int m);
        return m == 1 ? 1'b1 : m == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    function automatic bit quiet();
        return m_idle && !ad_pend && rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && rem[3] == 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input int n);
        cur_a[i] = a;
        cur_b[i] = b;
        rem[i]   = n;
        issued  += n;
    endtask

    task automatic reset_checks();
        check("rst out_STB", out_STB, 0);
        check("rst adder_input_STB", adder_input_STB, 0);
        check("rst adder_output_module_BUSY", adder_output_module_BUSY, 1);
        check("rst out_result", out_result, 0);
        check("rst out_id", out_id, 0);
        check("rst adder_a", adder_a, 0);
        check("rst adder_b", adder_b, 0);
        check("rst txn_count", txn_count, 0);
        check("rst req_BUSY", req_BUSY, 4'hF);
    endtask

    // capture pre-edge values and check the per-cycle expectations of the model
    task automatic snap();
        logic [3:0] exp_busy;
        s_req_stb = req_STB; s_req_busy = req_BUSY; s_a = req_a; s_b = req_b;
        s_ai_stb = adder_input_STB; s_a_busy = adder_BUSY; s_adder_a = adder_a; s_adder_b = adder_b;
        s_ao_stb = adder_output_STB; s_aomb = adder_output_module_BUSY;
        s_out_stb = out_STB; s_omb = output_module_BUSY; s_out_result = out_result; s_out_id = out_id;
        exp_busy = 4'hF;
        if (m_idle) begin
            for (int k = 0; k < 4; k++) begin
                if (req_STB[(m_ptr + k) % 4]) begin
                    exp_busy[(m_ptr + k) % 4] = 1'b0;
                    break;
                end
            end
        end
        check("req_BUSY", req_BUSY, exp_busy);
        check("adder_input_STB", adder_input_STB, m_issue);
        check("adder_output_module_BUSY", adder_output_module_BUSY, !m_wait);
        check("out_STB", out_STB, m_outstb);
    endtask

    // one clock: account for the transfers of the last edge, then drive the next inputs
    task automatic step();
        @(negedge clk);
        cyc++;
        if (cyc > 60000) begin
            $display("FAIL watchdog: %0d cycles used, limit 60000", cyc);
            $fatal(1, "watchdog");
        end
        for (int i = 0; i < 4; i++) begin
            if (s_req_stb[i] && !s_req_busy[i]) begin
                grant_log.push_back(i);
                m_idle = 0; m_issue = 1; m_owner = i;
                m_opa = s_a[16*i +: 16]; m_opb = s_b[16*i +: 16];
                m_res = bf_add(m_opa, m_opb);
                rem[i]--;
                if (rem[i] > 0) begin cur_a[i] = rnd_bf(); cur_b[i] = rnd_bf(); end
            end
        end
        if (s_ai_stb && s_a_busy) begin
            check("adder_a hold", adder_a, s_adder_a);
            check("adder_b hold", adder_b, s_adder_b);
        end
        if (s_ai_stb && !s_a_busy) begin
            check("adder_a", s_adder_a, m_opa);
            check("adder_b", s_adder_b, m_opb);
            m_issue = 0; m_wait = 1;
            ad_pend = 1; ad_cnt = $urandom_range(lat_lo, lat_hi); ad_val = bf_add(s_adder_a, s_adder_b);
        end
        if (s_ao_stb && !s_aomb) begin
            ad_pend = 0; m_wait = 0; m_outstb = 1;
            check("out_result", out_result, m_res);
            check("out_id", out_id, m_owner);
        end
        if (s_out_stb && s_omb) begin
            check("out_result hold", out_result, s_out_result);
            check("out_id hold", out_id, s_out_id);
        end
        if (s_out_stb && !s_omb) begin
            m_txn++; m_ptr = (m_owner + 1) % 4; m_idle = 1; m_outstb = 0;
            deliv_cnt++; last_res = s_out_result; last_id = s_out_id;
            check("txn_count", txn_count, m_txn);
        end
        if (ad_pend && !adder_output_STB) begin
            if (ad_cnt == 0) begin adder_output_STB = 1'b1; adder_sum = ad_val; end
            else ad_cnt--;
        end else if (!ad_pend) adder_output_STB = 1'b0;
        adder_BUSY = busy_of(a_busy_mode);
        output_module_BUSY = busy_of(o_busy_mode);
        for (int i = 0; i < 4; i++) begin
            req_STB[i] = rem[i] > 0;
            req_a[16*i +: 16] = cur_a[i];
            req_b[16*i +: 16] = cur_b[i];
        end
        #1 snap();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) rem[i] = 0;
        req_STB = 4'h0;
        m_idle = 1; m_issue = 0; m_wait = 0; m_outstb = 0; m_ptr = 0; m_txn = 16'h0;
        #1 reset_checks();
        @(negedge clk);
        rst = 1'b0;
        #1 snap();
    endtask

    function automatic bit reached(input int which);
        case (which)
            0: return quiet();
            1: return out_STB;
            2: return adder_input_STB;
            default: return m_wait && ad_pend;
        endcase
    endfunction

    task automatic wait_until(input int which, input string name);
        int n;
        n = 0;
        while (!reached(which) && n < 3000) begin step(); n++; end
        if (!reached(which)) begin
            checks++; errors++;
            $display("FAIL %s: not reached within 3000 cycles", name);
        end
    endtask

    initial begin
        int d0, i0;
        rst = 1'b0; req_STB = 4'h0; req_a = '0; req_b = '0;
        adder_BUSY = 1'b0; adder_sum = '0; adder_output_STB = 1'b0; output_module_BUSY = 1'b0;
        for (int i = 0; i < 4; i++) begin rem[i] = 0; cur_a[i] = '0; cur_b[i] = '0; end
        m_idle = 1; m_issue = 0; m_wait = 0; m_outstb = 0; m_ptr = 0; m_txn = 16'h0;
        ad_pend = 0; lat_lo = 0; lat_hi = 0; a_busy_mode = 0; o_busy_mode = 0;
        tbl[0] = '{2'd1, 16'h3F80, 16'h4000, 16'h4040, 16'd1};
        tbl[1] = '{2'd0, 16'h4000, 16'h4000, 16'h4080, 16'd2};
        tbl[2] = '{2'd2, 16'h3F80, 16'hBF80, 16'h0000, 16'd3};
        tbl[3] = '{2'd3, 16'h4040, 16'h3F80, 16'h4080, 16'd4};
        tbl[4] = '{2'd1, 16'h4120, 16'h3F80, 16'h4130, 16'd5};
        tbl[5] = '{2'd2, 16'hC000, 16'h3F00, 16'hBFC0, 16'd6};
        exp_rr = '{0, 1, 2, 3, 0};
        #1 rst = 1'b1;
        #1 reset_checks();
        @(negedge clk);
        rst = 1'b0;
        #1 snap();

        // directed single transactions with known sums
        for (int t = 0; t < 6; t++) begin
            d0 = deliv_cnt;
            set_req(tbl[t].id, tbl[t].a, tbl[t].b, 1);
            wait_until(0, "vector done");
            check("vec result", last_res, tbl[t].sum);
            check("vec id", last_id, tbl[t].id);
            check("vec deliveries", deliv_cnt, d0 + 1);
            check("vec txn_count", txn_count, tbl[t].cnt);
        end

        // all four requesting from reset: strict rotation starting at 0
        pulse_reset();
        grant_log.delete();
        for (int i = 0; i < 4; i++) set_req(i, rnd_bf(), rnd_bf(), i == 0 ? 2 : 1);
        wait_until(0, "rotation done");
        check("rotation grants", grant_log.size(), 5);
        for (int k = 0; k < grant_log.size() && k < 5; k++) check("rotation order", grant_log[k], exp_rr[k]);

        // consumer stalls for 10 cycles while another requester waits
        set_req(1, rnd_bf(), rnd_bf(), 1);
        set_req(3, rnd_bf(), rnd_bf(), 1);
        o_busy_mode = 1;
        wait_until(1, "out_STB raised");
        repeat (10) step();
        check("stalled out_STB", out_STB, 1);
        check("stalled req_BUSY", req_BUSY, 4'hF);
        o_busy_mode = 0;
        wait_until(0, "stall done");

        // adder refuses operands for 5 cycles
        a_busy_mode = 1;
        set_req(0, 16'h3F80, 16'h3F80, 1);
        wait_until(2, "adder_input_STB raised");
        repeat (5) step();
        check("adder stall strobe", adder_input_STB, 1);
        a_busy_mode = 0;
        wait_until(0, "adder stall done");
        check("adder stall result", last_res, 16'h4000);

        // requester 2 withdraws before grant: pointer must move only past requester 1
        pulse_reset();
        lat_lo = 4; lat_hi = 4;
        set_req(1, rnd_bf(), rnd_bf(), 1);
        repeat (2) step();
        set_req(2, rnd_bf(), rnd_bf(), 1);
        repeat (2) step();
        rem[2] = 0;
        wait_until(0, "withdraw done");
        grant_log.delete();
        set_req(0, rnd_bf(), rnd_bf(), 1);
        set_req(3, rnd_bf(), rnd_bf(), 1);
        wait_until(0, "post-withdraw done");
        check("post-withdraw grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("post-withdraw first", grant_log[0], 3);
            check("post-withdraw second", grant_log[1], 0);
        end
        lat_lo = 0; lat_hi = 0;

        // counter wrap: preload near the top, then two deliveries
        force dut.txn_count = 16'hFFFE;
        step();
        release dut.txn_count;
        m_txn = 16'hFFFE;
        set_req(2, 16'h3F80, 16'h3F80, 1);
        wait_until(0, "wrap-1 done");
        check("txn_count 0xFFFF", txn_count, 16'hFFFF);
        set_req(3, 16'h3F80, 16'h3F80, 1);
        wait_until(0, "wrap-2 done");
        check("txn_count wrap", txn_count, 16'h0000);

        // reset while waiting for the sum: the late sum must never be delivered
        lat_lo = 8; lat_hi = 8;
        set_req(0, rnd_bf(), rnd_bf(), 1);
        wait_until(3, "in WAIT_SUM");
        pulse_reset();
        repeat (12) step();
        check("discarded out_STB", out_STB, 0);
        ad_pend = 0; lat_lo = 0; lat_hi = 0;
        set_req(2, 16'h3F80, 16'h4000, 1);
        wait_until(0, "after-reset done");
        check("after-reset id", last_id, 2);
        check("after-reset result", last_res, 16'h4040);
        check("after-reset txn_count", txn_count, 1);

        // random traffic with random stalls and adder latency
        d0 = deliv_cnt; i0 = issued;
        a_busy_mode = 2; o_busy_mode = 2; lat_lo = 0; lat_hi = 3;
        for (int r = 0; r < 400; r++) begin
            int i;
            i = $urandom_range(0, 3);
            if (rem[i] == 0 && $urandom_range(0, 3) == 0) set_req(i, rnd_bf(), rnd_bf(), $urandom_range(1, 3));
            step();
        end
        wait_until(0, "random done");
        check("random deliveries", deliv_cnt - d0, issued - i0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
